// File: rtl/fum_mac_pkg.sv
// Shared definitions for the FUM floating-point MAC path.
//   DATA_W    : operand/result width (IEEE-754 single)
//   MAC_LAT   : cycles from MAC input sample to the matching result on mac_result
//   LEN_W     : width of the per-vector element counter
//   FP_ZERO / FP_ONE : FP32 constants
//   res_tag_t : result tag carried alongside each MAC input {last, count}
//   sat_inc   : saturating increment for the element counter
package fum_mac_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MAC_LAT = 4;
  localparam int unsigned LEN_W   = 16;

  localparam logic [DATA_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [DATA_W-1:0] FP_ONE  = 32'h3F80_0000;

  typedef struct packed {
    logic             last;
    logic [LEN_W-1:0] count;
  } res_tag_t;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dot_result_fifo.sv
// Synchronous show-ahead FIFO holding finished dot-product results.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wr_en_i, wr_data_i : write strobe and data
//   rd_en_i       : pop the head entry (ignored when empty)
//   rd_data_o     : head entry, zero while empty
//   count_o       : number of stored entries
//   empty_o       : no entries stored
// A write while full is accepted only if a pop happens in the same cycle.
module dot_result_fifo #(
  parameter int unsigned Width = 48,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [Width-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [Width-1:0]         rd_data_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    cnt_q;
  logic             do_wr, do_rd;

  assign empty_o   = (cnt_q == '0);
  assign do_rd     = rd_en_i & ~empty_o;
  assign do_wr     = wr_en_i & ((cnt_q != (PtrW+1)'(Depth)) | do_rd);
  assign rd_data_o = empty_o ? '0 : mem_q[rptr_q];
  assign count_o   = cnt_q;

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Initiator for the free-running FP MAC: turns a stream of FP32 operand pairs (vectors
// delimited by s_last) into accumulate-sequenced MAC inputs and returns one dot product
// per vector.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   s_valid/s_ready/s_a/s_b/s_last : operand-pair stream in
//   m_valid/m_ready/m_data/m_count : result stream out (sum and element count)
//   mac_ena/mac_clr/mac_accumulate/mac_ay/mac_az : registered MAC controls/operands
//   mac_result                 : MAC output, valid MAC_LAT cycles after the MAC samples
module mac_dot_sequencer
  import fum_mac_pkg::*;
#(
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_a,
  input  logic [DATA_W-1:0] s_b,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [LEN_W-1:0]  m_count,
  output logic              mac_ena,
  output logic              mac_clr,
  output logic              mac_accumulate,
  output logic [DATA_W-1:0] mac_ay,
  output logic [DATA_W-1:0] mac_az,
  input  logic [DATA_W-1:0] mac_result
);

  localparam int unsigned PipeN = MAC_LAT + 1;
  localparam int unsigned InfW  = $clog2(PipeN + 2) + 1;
  localparam int unsigned CntW  = $clog2(OUT_DEPTH) + 1;

  logic              rst_seen_q, mac_clr_q, mac_ena_q, acc_q;
  logic              first_q;
  logic [LEN_W-1:0]  elem_cnt_q;
  logic [DATA_W-1:0] ay_q, az_q;
  res_tag_t          tag_in_q;         // registered together with ay_q/az_q
  res_tag_t          pipe_q [PipeN];   // follows the MAC's internal latency
  res_tag_t          tag_in_d;

  logic                    accept;
  logic [InfW-1:0]         inflight_last;
  logic                    fifo_wr, fifo_rd, fifo_empty;
  logic [DATA_W+LEN_W-1:0] fifo_rdata;
  logic [CntW-1:0]         fifo_count;

  // Every last tag in flight has a reserved FIFO slot, so a write is never dropped.
  always_comb begin
    inflight_last = InfW'(tag_in_q.last);
    for (int i = 0; i < PipeN; i++) begin
      inflight_last = inflight_last + InfW'(pipe_q[i].last);
    end
  end

  assign s_ready = ~mac_clr_q & ((32'(inflight_last) + 32'(fifo_count)) < OUT_DEPTH);
  assign accept  = s_valid & s_ready;

  always_comb begin
    tag_in_d = '0;
    if (accept) begin
      tag_in_d.last  = s_last;
      tag_in_d.count = sat_inc(elem_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_seen_q <= 1'b0;
      mac_clr_q  <= 1'b1;
      mac_ena_q  <= 1'b0;
      acc_q      <= 1'b0;
      first_q    <= 1'b1;
      elem_cnt_q <= '0;
      ay_q       <= FP_ZERO;
      az_q       <= FP_ZERO;
      tag_in_q   <= '0;
      for (int i = 0; i < PipeN; i++) pipe_q[i] <= '0;
    end else begin
      // Hold clr for one full cycle after reset release, then run the MAC freely.
      rst_seen_q <= 1'b1;
      mac_clr_q  <= ~rst_seen_q;
      mac_ena_q  <= rst_seen_q;
      // Bubbles feed +0.0 with the same accumulate flag, so gaps leave the sum intact.
      acc_q      <= ~first_q;
      tag_in_q   <= tag_in_d;
      if (accept) begin
        ay_q       <= s_a;
        az_q       <= s_b;
        first_q    <= s_last;
        elem_cnt_q <= s_last ? '0 : sat_inc(elem_cnt_q);
      end else begin
        ay_q <= FP_ZERO;
        az_q <= FP_ZERO;
      end
      pipe_q[0] <= tag_in_q;
      for (int i = 1; i < PipeN; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign fifo_wr = pipe_q[PipeN-1].last;
  assign fifo_rd = m_valid & m_ready;

  dot_result_fifo #(
    .Width (DATA_W + LEN_W),
    .Depth (OUT_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (fifo_wr),
    .wr_data_i ({pipe_q[PipeN-1].count, mac_result}),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rdata),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty)
  );

  assign m_valid        = ~fifo_empty;
  assign m_data         = fifo_rdata[DATA_W-1:0];
  assign m_count        = fifo_rdata[DATA_W +: LEN_W];
  assign mac_ena        = mac_ena_q;
  assign mac_clr        = mac_clr_q;
  assign mac_accumulate = acc_q;
  assign mac_ay         = ay_q;
  assign mac_az         = az_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with a behavioural FP MAC attached.
module tb_mac_dot_sequencer;
  import fum_mac_pkg::*;

  localparam int unsigned OUT_DEPTH = 4;
  localparam logic [31:0] F2 = 32'h4000_0000;
  localparam logic [31:0] F3 = 32'h4040_0000;
  localparam logic [31:0] F4 = 32'h4080_0000;
  localparam logic [31:0] F5 = 32'h40A0_0000;
  localparam logic [31:0] F6 = 32'h40C0_0000;
  localparam logic [31:0] F7 = 32'h40E0_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
  logic [DATA_W-1:0] s_a = '0, s_b = '0;
  logic              s_ready, m_valid, mac_ena, mac_clr, mac_accumulate;
  logic [DATA_W-1:0] m_data, mac_ay, mac_az, mac_result;
  logic [LEN_W-1:0]  m_count;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, rise_cyc = 0, last_acc = 0;
  logic mv_prev = 1'b0;
  logic [31:0]      res_data [$];
  logic [LEN_W-1:0] res_cnt  [$];

  always #5 clk = ~clk;

  mac_dot_sequencer #(.OUT_DEPTH(OUT_DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_a            (s_a),
    .s_b            (s_b),
    .s_last         (s_last),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_count        (m_count),
    .mac_ena        (mac_ena),
    .mac_clr        (mac_clr),
    .mac_accumulate (mac_accumulate),
    .mac_ay         (mac_ay),
    .mac_az         (mac_az),
    .mac_result     (mac_result)
  );

  // ---------------- MAC model: result appears MAC_LAT edges after the sampling edge
  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'd0) return 0.0;
    d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic real mac_step(input real acc, input logic clr, input logic ena,
                                   input logic accum, input logic [31:0] a, b);
    if (clr) return 0.0;
    if (!ena) return acc;
    return (accum ? acc : 0.0) + f2r(a) * f2r(b);
  endfunction

  real         acc_m = 0.0;
  logic [31:0] dl_q [MAC_LAT+1];

  always @(posedge clk) begin
    acc_m    <= mac_step(acc_m, mac_clr, mac_ena, mac_accumulate, mac_ay, mac_az);
    dl_q[0]  <= r2f(mac_step(acc_m, mac_clr, mac_ena, mac_accumulate, mac_ay, mac_az));
    for (int i = 1; i <= MAC_LAT; i++) dl_q[i] <= dl_q[i-1];
  end
  assign mac_result = dl_q[MAC_LAT];

  // ---------------- monitors
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_valid && !mv_prev) rise_cyc <= cyc;
    mv_prev <= m_valid;
    if (m_valid && m_ready) begin
      res_data.push_back(m_data);
      res_cnt.push_back(m_count);
    end
  end

  // ---------------- helpers
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns #1 after the accepting edge so MAC-side registers show this beat.
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_a     = a;
    s_b     = b;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("beat_accept", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    s_valid  = 1'b0;
    last_acc = cyc;
  endtask

  task automatic wait_results(input int n);
    int k = 0;
    while (res_data.size() < n && k < 100) begin
      tick(1);
      k++;
    end
    check("result_count", 64'(res_data.size()), 64'(n));
  endtask

  task automatic pop_check(input string tag, input logic [31:0] d, input logic [LEN_W-1:0] c);
    if (res_data.size() == 0) begin
      check({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      check({tag, "_data"}, 64'(res_data.pop_front()), 64'(d));
      check({tag, "_count"}, 64'(res_cnt.pop_front()), 64'(c));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected end of test");
    $fatal(1);
  end

  // ---------------- stimulus
  initial begin
    // Reset values
    #12;
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_count", 64'(m_count), 64'd0);
    check("rst_mac_ena", 64'(mac_ena), 64'd0);
    check("rst_mac_clr", 64'(mac_clr), 64'd1);
    check("rst_mac_acc", 64'(mac_accumulate), 64'd0);
    check("rst_mac_ay", 64'(mac_ay), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_clr_hold", 64'(mac_clr), 64'd1);
    check("post_rst_ready_low", 64'(s_ready), 64'd0);
    tick(1);
    check("post_rst_clr_drop", 64'(mac_clr), 64'd0);
    check("post_rst_ena", 64'(mac_ena), 64'd1);

    // T1: 3 x (1.0*1.0), latency and count
    send_beat(FP_ONE, FP_ONE, 1'b0);
    check("t1_first_acc", 64'(mac_accumulate), 64'd0);
    send_beat(FP_ONE, FP_ONE, 1'b0);
    check("t1_second_acc", 64'(mac_accumulate), 64'd1);
    send_beat(FP_ONE, FP_ONE, 1'b1);
    wait_results(1);
    check("t1_latency", 64'(rise_cyc - last_acc), 64'(MAC_LAT + 2));
    pop_check("t1", F3, 3);
    tick(4);
    check("t1_single_result", 64'(res_data.size()), 64'd0);

    // T2: [1,1].[1,1] then [2].[2] back-to-back
    send_beat(FP_ONE, FP_ONE, 1'b0);
    send_beat(FP_ONE, FP_ONE, 1'b1);
    send_beat(F2, F2, 1'b1);
    check("t2_v2_acc", 64'(mac_accumulate), 64'd0);
    check("t2_v2_ay", 64'(mac_ay), 64'(F2));
    wait_results(2);
    pop_check("t2_v1", F2, 2);
    pop_check("t2_v2", F4, 1);

    // T3: 3-element vector with 2 idle cycles between beats
    send_beat(FP_ONE, FP_ONE, 1'b0);
    tick(1);
    check("t3_bubble_ay", 64'(mac_ay), 64'd0);
    check("t3_bubble_az", 64'(mac_az), 64'd0);
    check("t3_bubble_acc", 64'(mac_accumulate), 64'd1);
    tick(1);
    send_beat(FP_ONE, FP_ONE, 1'b0);
    tick(2);
    send_beat(FP_ONE, FP_ONE, 1'b1);
    wait_results(1);
    pop_check("t3", F3, 3);

    // T4: back-pressure, credit limits acceptance to OUT_DEPTH vectors
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(F2, F3, 1'b1);
    s_valid = 1'b1;
    s_a     = F2;
    s_b     = F3;
    s_last  = 1'b1;
    tick(12);
    check("t4_ready_blocked", 64'(s_ready), 64'd0);
    check("t4_results_held", 64'(m_valid), 64'd1);
    check("t4_none_popped", 64'(res_data.size()), 64'd0);
    m_ready = 1'b1;
    send_beat(F2, F3, 1'b1);
    send_beat(F2, F3, 1'b1);
    wait_results(6);
    for (int i = 0; i < 6; i++) pop_check("t4", F6, 1);

    // T5: reset mid-vector with one result queued
    m_ready = 1'b0;
    send_beat(F5, FP_ONE, 1'b1);
    tick(MAC_LAT + 4);
    check("t5_queued", 64'(m_valid), 64'd1);
    send_beat(FP_ONE, FP_ONE, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_m_valid", 64'(m_valid), 64'd0);
    check("t5_rst_clr", 64'(mac_clr), 64'd1);
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("t5_clr_hold", 64'(mac_clr), 64'd1);
    tick(1);
    check("t5_clr_drop", 64'(mac_clr), 64'd0);
    check("t5_no_stale", 64'(m_valid), 64'd0);
    m_ready = 1'b1;
    send_beat(FP_ONE, FP_ONE, 1'b1);
    wait_results(1);
    pop_check("t5", FP_ONE, 1);

    // T6: FIFO write of [3,4].[1,1] coincides with popping the previous result
    m_ready = 1'b0;
    send_beat(F2, FP_ONE, 1'b1);
    send_beat(F3, FP_ONE, 1'b0);
    send_beat(F4, FP_ONE, 1'b1);
    tick(MAC_LAT + 1);
    check("t6_head_before", 64'(m_data), 64'(F2));
    m_ready = 1'b1;
    tick(1);
    check("t6_valid_after", 64'(m_valid), 64'd1);
    check("t6_head_after", 64'(m_data), 64'(F7));
    check("t6_count_after", 64'(m_count), 64'd2);
    wait_results(2);
    pop_check("t6_v1", F2, 1);
    pop_check("t6_v2", F7, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
